ex_cmp_stage: RTL and testbench

Execute-stage compare unit for the RV32I core. It accepts decoded operands through a valid/ready handshake and computes SLT, SLTU and the six conditional-branch decisions. Signed compares are derived from the unsigned magnitude compare, and results are registered. Output passes through a 2-entry buffer (output register + skid register) so the EX/MEM interface can stall without losing instructions. Consumers are the writeback mux and the PC-redirect logic.

---
 rtl/ex_cmp_stage.sv | 137 +++++++++++++
 tb/tb_ex_cmp_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_cmp_stage.sv
// RV32I execute-stage compare unit: SLT/SLTU and the six branch decisions,
// with results held in a two-entry output buffer (output register + skid register).
module ex_cmp_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [RD_W-1:0] i_rd_addr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [RD_W-1:0] o_rd_addr,
  output logic            o_rd_wren,
  output logic            o_br_taken,
  output logic [XLEN-1:0] o_br_target,
  output logic            o_illegal
);

  localparam logic [XLEN-1:0] SIGN_MASK = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_addr;
    logic            rd_wren;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  state_e state_q;
  entry_t out_q;
  entry_t skid_q;
  entry_t entry_d;

  logic ltu;
  logic lt;
  logic eq;
  logic accept;
  logic drain;

  // Flipping the sign bits turns a signed compare into an unsigned one.
  assign ltu = (i_rs1_data < i_rs2_data);
  assign lt  = ((i_rs1_data ^ SIGN_MASK) < (i_rs2_data ^ SIGN_MASK));
  assign eq  = (i_rs1_data == i_rs2_data);

  always_comb begin
    // NOTE: default every field first so no path through the case leaves a latch.
    entry_d         = '0;
    entry_d.rd_addr = i_rd_addr;
    case (i_op)
      4'd0: begin
        entry_d.result  = {{(XLEN-1){1'b0}}, lt};
        entry_d.rd_wren = 1'b1;
      end
      4'd1: begin
        entry_d.result  = {{(XLEN-1){1'b0}}, ltu};
        entry_d.rd_wren = 1'b1;
      end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        entry_d.br_target = i_pc + i_imm;
        case (i_op)
          4'd2:    entry_d.br_taken = eq;
          4'd3:    entry_d.br_taken = !eq;
          4'd4:    entry_d.br_taken = lt;
          4'd5:    entry_d.br_taken = !lt;
          4'd6:    entry_d.br_taken = ltu;
          default: entry_d.br_taken = !ltu;
        endcase
      end
      default: entry_d.illegal = 1'b1;
    endcase
  end

  // Handshake flags come only from registered state, never from i_ready.
  assign o_valid = (state_q != ST_EMPTY);
  assign o_ready = (state_q != ST_FULL);
  assign accept  = i_valid && o_ready;
  assign drain   = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the payload registers are reset too, because the outputs must read zero in reset.
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q   <= entry_d;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_q <= entry_d;
          end else if (accept) begin
            skid_q  <= entry_d;
            state_q <= ST_FULL;
          end else if (drain) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_q   <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign o_result    = out_q.result;
  assign o_rd_addr   = out_q.rd_addr;
  assign o_rd_wren   = out_q.rd_wren;
  assign o_br_taken  = out_q.br_taken;
  assign o_br_target = out_q.br_target;
  assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_ex_cmp_stage.sv
// Self-checking bench for ex_cmp_stage: directed vector table, backpressure and
// reset sequences, and randomized traffic scored against a queue-based model.
module tb_ex_cmp_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] i_pc;
  logic [31:0] i_imm;
  logic [4:0]  i_rd_addr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;
  logic        o_rd_wren;
  logic        o_br_taken;
  logic [31:0] o_br_target;
  logic        o_illegal;

  ex_cmp_stage #(.XLEN(32), .RD_W(5)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .i_pc        (i_pc),
    .i_imm       (i_imm),
    .i_rd_addr   (i_rd_addr),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_rd_addr   (o_rd_addr),
    .o_rd_wren   (o_rd_wren),
    .o_br_taken  (o_br_taken),
    .o_br_target (o_br_target),
    .o_illegal   (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wren;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    exp_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  exp_t model_q[$];
  vec_t vq[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t dut_out();
    return {o_result, o_rd_addr, o_rd_wren, o_br_taken, o_br_target, o_illegal};
  endfunction

  function automatic exp_t mk(input logic [31:0] result, input logic [4:0] rd, input logic wren,
                              input logic taken, input logic [31:0] target, input logic illegal);
    exp_t e;
    e.result = result; e.rd = rd; e.wren = wren;
    e.taken = taken; e.target = target; e.illegal = illegal;
    return e;
  endfunction

  // Reference behaviour straight from the ISA rules using native signed/unsigned compares.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    exp_t e;
    e    = '0;
    e.rd = rd;
    if (op > 4'd7) begin
      e.illegal = 1'b1;
    end else if (op < 4'd2) begin
      e.wren   = 1'b1;
      e.result = (op == 4'd0) ? 32'($signed(a) < $signed(b)) : 32'(a < b);
    end else begin
      e.target = pc + imm;
      case (op)
        4'd2:    e.taken = (a == b);
        4'd3:    e.taken = (a != b);
        4'd4:    e.taken = ($signed(a) < $signed(b));
        4'd5:    e.taken = ($signed(a) >= $signed(b));
        4'd6:    e.taken = (a < b);
        default: e.taken = (a >= b);
      endcase
    end
    return e;
  endfunction

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd, input exp_t exp);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.pc = pc; v.imm = imm; v.rd = rd; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    i_valid = 1'b1; i_op = op; i_rs1_data = a; i_rs2_data = b;
    i_pc = pc; i_imm = imm; i_rd_addr = rd;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: sampled mid-cycle while inputs are stable; queue depth models occupancy.
  always @(negedge clk) begin
    if (mon_en) begin
      bit drain_m;
      bit accept_m;
      check("mon_valid", 96'(o_valid), 96'(model_q.size() > 0));
      check("mon_ready", 96'(o_ready), 96'(model_q.size() < 2));
      if (model_q.size() > 0) check("mon_payload", 96'(dut_out()), 96'(model_q[0]));
      drain_m  = (model_q.size() > 0) && i_ready;
      accept_m = i_valid && (model_q.size() < 2);
      if (drain_m) void'(model_q.pop_front());
      if (accept_m) model_q.push_back(ref_model(i_op, i_rs1_data, i_rs2_data, i_pc, i_imm, i_rd_addr));
    end
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = '0; i_rs1_data = '0; i_rs2_data = '0; i_pc = '0; i_imm = '0; i_rd_addr = '0;

    add_vec("sltu_1_vs_m1",    4'd1, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd5,  mk(32'd1, 5'd5, 1, 0, 32'h0, 0));
    add_vec("slt_1_vs_m1",     4'd0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd6,  mk(32'd0, 5'd6, 1, 0, 32'h0, 0));
    add_vec("slt_min_vs_max",  4'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 5'd7, mk(32'd1, 5'd7, 1, 0, 32'h0, 0));
    add_vec("sltu_min_vs_max", 4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 5'd8, mk(32'd0, 5'd8, 1, 0, 32'h0, 0));
    add_vec("slt_equal",       4'd0, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 32'h0, 5'd9, mk(32'd0, 5'd9, 1, 0, 32'h0, 0));
    add_vec("sltu_equal",      4'd1, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 32'h0, 5'd10, mk(32'd0, 5'd10, 1, 0, 32'h0, 0));
    add_vec("bgeu_equal_wrap", 4'd7, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFF8, 32'h10, 5'd11, mk(32'd0, 5'd11, 0, 1, 32'h8, 0));
    add_vec("beq_equal",       4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 32'hFFFF_FFFC, 5'd12, mk(32'd0, 5'd12, 0, 1, 32'hFC, 0));
    add_vec("bne_equal",       4'd3, 32'h5, 32'h5, 32'h200, 32'h8, 5'd13, mk(32'd0, 5'd13, 0, 0, 32'h208, 0));
    add_vec("blt_min_vs_max",  4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h40, 5'd14, mk(32'd0, 5'd14, 0, 1, 32'h40, 0));
    add_vec("bge_m1_vs_1",     4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'hFFFF_F000, 5'd15, mk(32'd0, 5'd15, 0, 0, 32'h0, 0));
    add_vec("bge_equal",       4'd5, 32'h7, 32'h7, 32'h10, 32'h10, 5'd16, mk(32'd0, 5'd16, 0, 1, 32'h20, 0));
    add_vec("bltu_min_vs_max", 4'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4, 32'h4, 5'd17, mk(32'd0, 5'd17, 0, 0, 32'h8, 0));
    add_vec("illegal_c",       4'hC, 32'h1, 32'h2, 32'h100, 32'h4, 5'd18, mk(32'd0, 5'd18, 0, 0, 32'h0, 1));
    add_vec("illegal_f",       4'hF, 32'h5, 32'h5, 32'h100, 32'h4, 5'd19, mk(32'd0, 5'd19, 0, 0, 32'h0, 1));

    #3;
    check("reset_valid",  96'(o_valid), 96'd0);
    check("reset_ready",  96'(o_ready), 96'd1);
    check("reset_fields", 96'(dut_out()), 96'd0);
    #9 rst_n = 1'b1;

    // Directed table: one op at a time, checked one cycle after acceptance.
    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].op, vq[i].a, vq[i].b, vq[i].pc, vq[i].imm, vq[i].rd);
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      check({vq[i].name, "_valid"}, 96'(o_valid), 96'd1);
      check(vq[i].name, 96'(dut_out()), 96'(vq[i].exp));
    end
    @(posedge clk); #1;
    model_q.delete();
    mon_en = 1'b1;

    // Backpressure: three back-to-back ops with the consumer stalled.
    i_ready = 1'b0;
    drive(4'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 5'd1);
    @(posedge clk); #1;
    drive(4'd3, 32'h5, 32'h6, 32'h1000, 32'h20, 5'd2);
    @(posedge clk); #1;
    drive(4'd1, 32'h3, 32'h2, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    check("bp_ready_low", 96'(o_ready), 96'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_ready_held", 96'(o_ready), 96'd0);
    check("bp_head_result", 96'(o_result), 96'd1);
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_all_drained", 96'(model_q.size()), 96'd0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a;
      @(posedge clk); #1;
      a = rand_operand();
      drive(($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
            a, ($urandom_range(0, 3) == 0) ? a : rand_operand(), $urandom, $urandom, 5'($urandom));
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 4) < 3);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rand_all_drained", 96'(model_q.size()), 96'd0);

    // Asynchronous reset while both entries are occupied.
    @(posedge clk); #1;
    mon_en = 1'b0;
    i_ready = 1'b0;
    drive(4'd1, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd7);
    @(posedge clk); #1;
    drive(4'd2, 32'h9, 32'h9, 32'hF0, 32'h10, 5'd8);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("rst_full_ready",  96'(o_ready), 96'd0);
    check("rst_full_result", 96'(o_result), 96'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid",  96'(o_valid), 96'd0);
    check("rst_async_ready",  96'(o_ready), 96'd1);
    check("rst_async_fields", 96'(dut_out()), 96'd0);
    #4 rst_n = 1'b1;
    i_ready = 1'b1;
    model_q.delete();
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    drive(4'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd4);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_drained", 96'(model_q.size()), 96'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
